// File: rtl/up_down_mod_counter.sv
// rtl/up_down_mod_counter.sv - up/down counter with programmable modulus, step, wrap/saturate and sticky flags
//
// Purpose:
//   Counts up or down by a programmable step within the range 0..limit.
//   On leaving that range it either wraps modulo (limit+1) or saturates at
//   the bound. It pulses tc on every such event and records the direction
//   in sticky ovf/unf flags. A synchronous load takes priority over counting.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   en         in   count enable (ignored while load=1)
//   load       in   synchronous load of min(data_in, limit)
//   up_down    in   1 = count up, 0 = count down
//   data_in    in   [WIDTH-1:0]  load value
//   step       in   [STEP_W-1:0] increment/decrement amount
//   limit      in   [WIDTH-1:0]  upper bound of the legal range
//   sat_mode   in   1 = saturate at bounds, 0 = wrap
//   clr_flags  in   synchronous clear of ovf/unf (a same-cycle set wins)
//   count      out  [WIDTH-1:0]  registered counter value
//   tc         out  registered terminal-count pulse
//   ovf        out  registered sticky overflow flag
//   unf        out  registered sticky underflow flag
//   at_limit   out  combinational count == limit
//   at_zero    out  combinational count == 0

module up_down_mod_counter #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic              up_down,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic              sat_mode,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              ovf,
  output logic              unf,
  output logic              at_limit,
  output logic              at_zero
);

  // One extra bit is enough: count <= 2^W-1 and s <= 2^W, so every
  // intermediate value below stays under 2^(W+1).
  localparam int XW = WIDTH + 1;
  typedef logic [XW-1:0] ext_t;

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  ext_t cnt_x;
  ext_t lim_x;
  ext_t mod_x;
  ext_t stp_x;
  ext_t s_x;
  ext_t sum_x;
  ext_t wrap_up_x;
  ext_t wrap_dn_x;
  ext_t nxt_x;
  logic ovf_evt;
  logic unf_evt;
  logic cnt_enable;

  // Arithmetic for the enabled-count path, evaluated every cycle.
  always_comb begin
    cnt_x     = {1'b0, count_q};
    lim_x     = {1'b0, limit};
    mod_x     = lim_x + ext_t'(1);
    stp_x     = ext_t'(step);
    // Clamp the step to the modulus so a single move never spans more
    // than one full turn of the range.
    s_x       = (stp_x > mod_x) ? mod_x : stp_x;
    sum_x     = cnt_x + s_x;
    // Only consumed when sum_x > limit, i.e. sum_x >= mod_x: no underflow.
    wrap_up_x = sum_x - mod_x;
    // Only consumed when count <= limit and count < s, so it lands in 0..limit.
    wrap_dn_x = cnt_x + mod_x - s_x;

    nxt_x   = cnt_x;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;

    if (up_down) begin
      if (sum_x > lim_x) begin
        ovf_evt = 1'b1;
        if (sat_mode) begin
          nxt_x = lim_x;
        end else if (wrap_up_x > lim_x) begin
          // Still out of range: count started above a lowered limit.
          nxt_x = '0;
        end else begin
          nxt_x = wrap_up_x;
        end
      end else begin
        nxt_x = sum_x;
      end
    end else begin
      if (cnt_x > lim_x) begin
        // Counting down from above the range is reported as an overflow.
        ovf_evt = 1'b1;
        nxt_x   = sat_mode ? lim_x : '0;
      end else if (cnt_x < s_x) begin
        unf_evt = 1'b1;
        nxt_x   = sat_mode ? '0 : wrap_dn_x;
      end else begin
        nxt_x = cnt_x - s_x;
      end
    end
  end

  // Next-state selection: load, then enabled count, then hold.
  always_comb begin
    cnt_enable = en & ~load;
    count_d    = count_q;
    tc_d       = 1'b0;

    if (load) begin
      count_d = (data_in > limit) ? limit : data_in;
    end else if (en) begin
      count_d = WIDTH'(nxt_x);
      tc_d    = ovf_evt | unf_evt;
    end

    // Clear first, then OR in the event so a same-cycle set survives.
    ovf_d = (ovf_q & ~clr_flags) | (cnt_enable & ovf_evt);
    unf_d = (unf_q & ~clr_flags) | (cnt_enable & unf_evt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count    = count_q;
  assign tc       = tc_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;
  assign at_limit = (count_q == limit);
  assign at_zero  = (count_q == '0);

endmodule

// File: tb/tb_up_down_mod_counter.sv
// tb/tb_up_down_mod_counter.sv - self-checking bench for up_down_mod_counter

module tb_up_down_mod_counter;

  localparam int W  = 4;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic          load = 1'b0;
  logic          up_down = 1'b1;
  logic [W-1:0]  data_in = '0;
  logic [SW-1:0] step = '0;
  logic [W-1:0]  limit = '0;
  logic          sat_mode = 1'b0;
  logic          clr_flags = 1'b0;

  logic [W-1:0]  count;
  logic          tc, ovf, unf, at_limit, at_zero;

  // {count, tc, ovf, unf, at_limit, at_zero}
  typedef logic [W+4:0] obs_t;

  obs_t sb[$];
  obs_t exp_v;
  obs_t got_v;
  int   total = 0;
  int   bad = 0;
  int   m_cnt = 0;
  bit   m_ovf = 1'b0;
  bit   m_unf = 1'b0;

  always #5 clk = ~clk;

  up_down_mod_counter #(.WIDTH(W), .STEP_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .up_down   (up_down),
    .data_in   (data_in),
    .step      (step),
    .limit     (limit),
    .sat_mode  (sat_mode),
    .clr_flags (clr_flags),
    .count     (count),
    .tc        (tc),
    .ovf       (ovf),
    .unf       (unf),
    .at_limit  (at_limit),
    .at_zero   (at_zero)
  );

  function automatic obs_t observe();
    return {count, tc, ovf, unf, at_limit, at_zero};
  endfunction

  // Reference model in plain integers; returns the expected post-edge view.
  task automatic model(output obs_t e);
    int lim, c, s;
    bit t, oe, ue;
    lim = int'(limit);
    c   = m_cnt;
    s   = (int'(step) > lim + 1) ? lim + 1 : int'(step);
    t = 0; oe = 0; ue = 0;
    if (load) begin
      c = (int'(data_in) > lim) ? lim : int'(data_in);
    end else if (en) begin
      if (up_down) begin
        if (c + s > lim) begin
          oe = 1;
          if (sat_mode) c = lim;
          else begin
            c = c + s - (lim + 1);
            if (c > lim) c = 0;
          end
        end else c = c + s;
      end else begin
        if (c > lim) begin
          oe = 1;
          c = sat_mode ? lim : 0;
        end else if (c < s) begin
          ue = 1;
          c = sat_mode ? 0 : c + lim + 1 - s;
        end else c = c - s;
      end
      t = oe | ue;
    end
    if (clr_flags) begin
      m_ovf = 0;
      m_unf = 0;
    end
    m_ovf = m_ovf | oe;
    m_unf = m_unf | ue;
    m_cnt = c;
    e = {W'(c), t, m_ovf, m_unf, (c == lim), (c == 0)};
  endtask

  // Push the expectation for the current inputs, then clock once and settle.
  task automatic cycle();
    obs_t e;
    model(e);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    limit = 4'd9;
    #2 rst_n = 1'b0;
    #1;
    got_v = observe();
    total++;
    if (got_v !== {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state got=%h exp=%h", got_v, {4'd0, 5'b00001});
    end
    en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (count !== 4'd0) begin
      bad++;
      $display("FAIL reset_hold got=%0d exp=0", count);
    end
    en = 1'b0;
    rst_n = 1'b1;
    m_cnt = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic test_up_wrap();
    limit = 4'd9; step = 4'd1; up_down = 1'b1; sat_mode = 1'b0; en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      exp_v = sb.pop_front();
      got_v = observe();
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL up_wrap_model[%0d] got=%h exp=%h", i, got_v, exp_v);
      end
      total++;
      if ({count, tc, ovf} !== {4'(i % 10), (i == 10), (i == 10)}) begin
        bad++;
        $display("FAIL up_wrap_seq[%0d] got=%0d/%b/%b exp=%0d/%b/%b",
                 i, count, tc, ovf, i % 10, (i == 10), (i == 10));
      end
    end
  endtask

  task automatic test_down_under();
    for (int k = 0; k < 2; k++) begin
      en = 1'b0; load = 1'b1; data_in = 4'd2; sat_mode = k[0];
      cycle();
      exp_v = sb.pop_front();
      got_v = observe();
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL down_load[%0d] got=%h exp=%h", k, got_v, exp_v);
      end
      load = 1'b0; en = 1'b1; up_down = 1'b0; step = 4'd3;
      for (int j = 0; j < 3; j++) begin
        cycle();
        exp_v = sb.pop_front();
        got_v = observe();
        total++;
        if (got_v !== exp_v) begin
          bad++;
          $display("FAIL down_model[%0d.%0d] got=%h exp=%h", k, j, got_v, exp_v);
        end
        if (k == 0) break;
      end
      total++;
      if ({count, tc, unf} !== {(k == 0) ? 4'd9 : 4'd0, 1'b1, 1'b1}) begin
        bad++;
        $display("FAIL down_final[%0d] got=%0d/%b/%b exp=%0d/1/1",
                 k, count, tc, unf, (k == 0) ? 9 : 0);
      end
    end
  endtask

  task automatic test_load_clamp();
    en = 1'b0; clr_flags = 1'b1;
    cycle();
    exp_v = sb.pop_front();
    got_v = observe();
    total++;
    if (got_v !== exp_v || ovf !== 1'b0 || unf !== 1'b0) begin
      bad++;
      $display("FAIL clr_idle got=%h exp=%h", got_v, exp_v);
    end
    clr_flags = 1'b0;
    limit = 4'd9; load = 1'b1; en = 1'b1; data_in = 4'd12;
    cycle();
    exp_v = sb.pop_front();
    got_v = observe();
    total++;
    if (got_v !== exp_v || {count, tc, ovf, unf} !== {4'd9, 3'b000}) begin
      bad++;
      $display("FAIL load_clamp got=%h exp=%h", got_v, exp_v);
    end
    load = 1'b0; limit = 4'd5; step = 4'd1; up_down = 1'b1; sat_mode = 1'b1;
    cycle();
    exp_v = sb.pop_front();
    got_v = observe();
    total++;
    if (got_v !== exp_v || {count, tc, ovf} !== {4'd5, 2'b11}) begin
      bad++;
      $display("FAIL lowered_limit got=%h exp=%h", got_v, exp_v);
    end
  endtask

  task automatic test_clr_priority();
    clr_flags = 1'b1; en = 1'b1;
    cycle();
    exp_v = sb.pop_front();
    got_v = observe();
    total++;
    if (got_v !== exp_v || ovf !== 1'b1) begin
      bad++;
      $display("FAIL clr_vs_set got=%h exp=%h", got_v, exp_v);
    end
    en = 1'b0;
    cycle();
    exp_v = sb.pop_front();
    got_v = observe();
    total++;
    if (got_v !== exp_v || ovf !== 1'b0 || tc !== 1'b0) begin
      bad++;
      $display("FAIL clr_alone got=%h exp=%h", got_v, exp_v);
    end
    clr_flags = 1'b0;
  endtask

  task automatic test_step_edges();
    // big step clamps to the modulus; zero step holds; limit=0 always overflows
    limit = 4'd3; sat_mode = 1'b0; up_down = 1'b1; en = 1'b0; load = 1'b1; data_in = 4'd1;
    cycle();
    void'(sb.pop_front());
    load = 1'b0; en = 1'b1; step = 4'hF;
    cycle();
    exp_v = sb.pop_front();
    got_v = observe();
    total++;
    if (got_v !== exp_v || {count, tc, ovf} !== {4'd1, 2'b11}) begin
      bad++;
      $display("FAIL big_step got=%h exp=%h", got_v, exp_v);
    end
    limit = 4'd0; step = 4'd1;
    for (int k = 0; k < 2; k++) begin
      sat_mode = k[0];
      cycle();
      exp_v = sb.pop_front();
      got_v = observe();
      total++;
      if (got_v !== exp_v || {count, tc, at_limit, at_zero} !== {4'd0, 3'b111}) begin
        bad++;
        $display("FAIL limit_zero[%0d] got=%h exp=%h", k, got_v, exp_v);
      end
    end
    limit = 4'd9; load = 1'b1; data_in = 4'd4;
    cycle();
    void'(sb.pop_front());
    load = 1'b0; step = 4'd0;
    for (int k = 0; k < 2; k++) begin
      up_down = k[0];
      cycle();
      exp_v = sb.pop_front();
      got_v = observe();
      total++;
      if (got_v !== exp_v || count !== 4'd4 || tc !== 1'b0) begin
        bad++;
        $display("FAIL zero_step[%0d] got=%h exp=%h", k, got_v, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    limit = 4'd15; up_down = 1'b1; sat_mode = 1'b0; step = 4'd2;
    en = 1'b0; load = 1'b1; data_in = 4'd1;
    cycle();
    void'(sb.pop_front());
    load = 1'b0; en = 1'b1;
    for (int j = 0; j < 3; j++) begin
      cycle();
      exp_v = sb.pop_front();
      got_v = observe();
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL pre_reset[%0d] got=%h exp=%h", j, got_v, exp_v);
      end
    end
    total++;
    if (count !== 4'd7) begin
      bad++;
      $display("FAIL reach_seven got=%0d exp=7", count);
    end
    #2 rst_n = 1'b0;
    #1;
    got_v = observe();
    total++;
    if (got_v !== {4'd0, 3'b000, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL async_clear got=%h exp=%h", got_v, {4'd0, 5'b00001});
    end
    rst_n = 1'b1;
    m_cnt = 0; m_ovf = 0; m_unf = 0;
    for (int j = 1; j <= 2; j++) begin
      cycle();
      exp_v = sb.pop_front();
      got_v = observe();
      total++;
      if (got_v !== exp_v || count !== 4'(2 * j)) begin
        bad++;
        $display("FAIL post_reset[%0d] got=%h exp=%h", j, got_v, exp_v);
      end
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 300; j++) begin
      en        = ($urandom_range(0, 3) != 0);
      load      = ($urandom_range(0, 9) == 0);
      up_down   = $urandom_range(0, 1);
      sat_mode  = ($urandom_range(0, 3) == 0);
      clr_flags = ($urandom_range(0, 7) == 0);
      data_in   = W'($urandom);
      step      = SW'($urandom_range(0, 5) == 0 ? $urandom : $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) limit = W'($urandom);
      cycle();
      exp_v = sb.pop_front();
      got_v = observe();
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL random[%0d] got=%h exp=%h", j, got_v, exp_v);
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_under();
    test_load_clamp();
    test_clr_priority();
    test_step_edges();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
